// File: rtl/block_match_pkg.sv
// Shared types and per-third geometry helpers for the block-match frame buffer.
package block_match_pkg;

    typedef enum logic [1:0] {EMPTY, READY, STALL} bank_state_e;

    function automatic bit third_is_edge(input int i, input int num_thirds);
        return (i == 0) || (i == num_thirds - 1);
    endfunction

    // Inner thirds carry overlap padding on both sides so matchers can see across the seam.
    function automatic int third_wr_depth(input int i, input int num_thirds, input int third_w,
                                          input int third_h, input int pad, input int wr_w);
        int width;
        width = third_is_edge(i, num_thirds) ? third_w : third_w + 2 * pad;
        return (width * third_h * 2) / wr_w;
    endfunction

    function automatic int third_rd_depth(input int i, input int num_thirds, input int third_w,
                                          input int third_h, input int pad, input int wr_w,
                                          input int rd_w);
        return third_wr_depth(i, num_thirds, third_w, third_h, pad, wr_w) * (wr_w / rd_w);
    endfunction

endpackage

// File: rtl/bm_bank_ctrl.sv
// Ping-pong bank ownership FSM; optional drop statistics under BM_FB_STATS_EN.
module bm_bank_ctrl
    import block_match_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_frame_done,
    input  logic        rd_frame_done,
`ifdef BM_FB_STATS_EN
    input  logic        write_rejected,
    output logic [15:0] dropped_writes,
    output logic [15:0] dropped_frames,
`endif
    output logic        wr_ready,
    output logic        rd_frame_valid,
    output logic        wr_bank,
    output logic        rd_bank
);
    bank_state_e state, state_next;
    logic        swap;
    logic        valid_next;
    logic        ready_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= EMPTY;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b1;
            rd_frame_valid <= 1'b0;
            wr_ready       <= 1'b1;
        end else begin
            state          <= state_next;
            rd_frame_valid <= valid_next;
            wr_ready       <= ready_next;
            if (swap) begin
                wr_bank <= ~wr_bank;
                rd_bank <= wr_bank;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (wr_frame_done) state_next = READY;
            READY: begin
                if (wr_frame_done && !rd_frame_done)      state_next = STALL;
                else if (!wr_frame_done && rd_frame_done) state_next = EMPTY;
            end
            STALL: if (rd_frame_done) state_next = READY;
            default: state_next = EMPTY;
        endcase
    end

    // Banks swap whenever a finished write frame can be handed to the readers.
    always_comb begin
        swap       = 1'b0;
        valid_next = (state_next != EMPTY);
        ready_next = (state_next != STALL);
        case (state)
            EMPTY:   swap = wr_frame_done;
            READY:   swap = wr_frame_done && rd_frame_done;
            STALL:   swap = rd_frame_done;
            default: swap = 1'b0;
        endcase
    end

`ifdef BM_FB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_writes <= '0;
            dropped_frames <= '0;
        end else begin
            if (write_rejected && (dropped_writes != 16'hFFFF)) begin
                dropped_writes <= dropped_writes + 16'd1;
            end
            if (wr_frame_done && (state == STALL) && (dropped_frames != 16'hFFFF)) begin
                dropped_frames <= dropped_frames + 16'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/bram_wrapper.sv
// Simple dual-port RAM: wide write port, narrow registered read port (low lane first).
module bram_wrapper #(
    parameter int DEPTH    = 7200,
    parameter int RD_DEPTH = 14400,
    parameter int WR_W     = 16,
    parameter int RD_W     = 8,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WR_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RD_W-1:0]   rd_data
);
    localparam int RATIO = WR_W / RD_W;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WR_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] rd_word;
    logic [ADDR_W-1:0] rd_lane;

    assign rd_word = rd_addr / ADDR_W'(RATIO);
    assign rd_lane = rd_addr % ADDR_W'(RATIO);

    always_ff @(posedge clk) begin
        if (we && (wr_addr < ADDR_W'(DEPTH))) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
        if (rd_addr < ADDR_W'(RD_DEPTH)) begin
            rd_data <= RD_W'(mem[rd_word[IW-1:0]] >> (rd_lane * ADDR_W'(RD_W)));
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/block_match_frame_buffer.sv
// Double-buffered per-third image store; BM_FB_STATS_EN adds dropped_writes/dropped_frames.
module block_match_frame_buffer
    import block_match_pkg::*;
#(
    parameter int NUM_THIRDS = 3,
    parameter int THIRD_W    = 240,
    parameter int THIRD_H    = 480,
    parameter int PAD        = 32,
    parameter int WR_W       = 16,
    parameter int RD_W       = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write,
    input  logic [$clog2(NUM_THIRDS)-1:0] wr_third,
    input  logic [ADDR_W-1:0]            wr_address,
    input  logic [WR_W-1:0]              wr_data,
    input  logic                         wr_frame_done,
    output logic                         wr_ready,
    input  logic [NUM_THIRDS*ADDR_W-1:0] rd_address,
    output logic [NUM_THIRDS*RD_W-1:0]   rd_data,
    input  logic                         rd_frame_done,
    output logic                         rd_frame_valid,
    output logic                         wr_bank,
`ifdef BM_FB_STATS_EN
    output logic [15:0]                  dropped_writes,
    output logic [15:0]                  dropped_frames,
`endif
    output logic                         rd_bank
);
    localparam int TW = $clog2(NUM_THIRDS);

    logic [NUM_THIRDS-1:0] wr_hit;
    logic                  sel_q;

    bm_bank_ctrl u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .wr_frame_done  (wr_frame_done),
        .rd_frame_done  (rd_frame_done),
`ifdef BM_FB_STATS_EN
        .write_rejected (write && !(|wr_hit)),
        .dropped_writes (dropped_writes),
        .dropped_frames (dropped_frames),
`endif
        .wr_ready       (wr_ready),
        .rd_frame_valid (rd_frame_valid),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank)
    );

    // The bank choice travels alongside the address so a swap mid-read cannot mix banks.
    always_ff @(posedge clk) begin
        if (reset) sel_q <= 1'b1;
        else       sel_q <= rd_bank;
    end

    for (genvar t = 0; t < NUM_THIRDS; t++) begin : g_third
        localparam int WDEPTH = third_wr_depth(t, NUM_THIRDS, THIRD_W, THIRD_H, PAD, WR_W);
        localparam int RDEPTH = third_rd_depth(t, NUM_THIRDS, THIRD_W, THIRD_H, PAD, WR_W, RD_W);

        logic [RD_W-1:0] q0, q1, mux_q;

        assign wr_hit[t] = write && wr_ready && (wr_third == TW'(t))
                           && (wr_address < ADDR_W'(WDEPTH));

        bram_wrapper #(.DEPTH(WDEPTH), .RD_DEPTH(RDEPTH), .WR_W(WR_W), .RD_W(RD_W), .ADDR_W(ADDR_W)) u_bank0 (
            .clk     (clk),
            .we      (wr_hit[t] && !wr_bank),
            .wr_addr (wr_address),
            .wr_data (wr_data),
            .rd_addr (rd_address[t*ADDR_W +: ADDR_W]),
            .rd_data (q0)
        );

        bram_wrapper #(.DEPTH(WDEPTH), .RD_DEPTH(RDEPTH), .WR_W(WR_W), .RD_W(RD_W), .ADDR_W(ADDR_W)) u_bank1 (
            .clk     (clk),
            .we      (wr_hit[t] && wr_bank),
            .wr_addr (wr_address),
            .wr_data (wr_data),
            .rd_addr (rd_address[t*ADDR_W +: ADDR_W]),
            .rd_data (q1)
        );

        always_ff @(posedge clk) begin
            if (reset) mux_q <= '0;
            else       mux_q <= sel_q ? q1 : q0;
        end

        assign rd_data[t*RD_W +: RD_W] = mux_q;
    end

endmodule
